// File: rtl/jk_pkg.sv
// Shared encodings and the per-bit excitation helper for the JK bank driver.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // {J,K} excitation codes
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Set/reset excitation that moves a cell from q to target; hold when already there.
    function automatic logic [1:0] jk_excite(input logic target, input logic q);
        if (target == q)
            return JK_HOLD;
        else if (target)
            return JK_SET;
        else
            return JK_RST;
    endfunction

endpackage

// File: rtl/jk_bank_driver_if.sv
// Request/response and cell-side signal bundle for the JK bank driver.
interface jk_bank_driver_if #(
    parameter int WIDTH = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_mode;
    logic [WIDTH-1:0] req_data;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] fail_bits;

    modport master (
        output req_valid, req_mode, req_data, q_fb,
        input  req_ready, j_out, k_out, busy, done, err, fail_bits
    );

    modport slave (
        input  req_valid, req_mode, req_data, q_fb,
        output req_ready, j_out, k_out, busy, done, err, fail_bits
    );
endinterface

// File: rtl/jk_bank_driver.sv
// Drives J/K excitation into a bank of external JK cells, reads Q back,
// verifies against the expected vector and retries up to MAX_RETRY times.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    jk_bank_driver_if.slave bus
);

    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    state_t           r_state;
    state_t           w_next;
    logic             r_mode;
    logic             r_first;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_expected;
    logic [WIDTH-1:0] r_fail_bits;
    logic [2:0]       r_retry;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic             w_match;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    assign w_match  = (bus.q_fb == r_expected);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = DRIVE;
            DRIVE:   w_next = CHECK;
            CHECK:   w_next = (w_match || (r_retry == MAX_R)) ? IDLE : DRIVE;
            default: w_next = IDLE;
        endcase
    end

    // First pass in toggle mode uses JK_TOG on the mask; every other pass,
    // including retries of a toggle request, steers each cell toward a known value.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [1:0] w_code;
        always_comb begin
            w_code = JK_HOLD;
            if (r_state == DRIVE) begin
                if (r_first && r_mode)
                    w_code = r_data[gi] ? JK_TOG : JK_HOLD;
                else
                    w_code = jk_excite(r_first ? r_data[gi] : r_expected[gi], bus.q_fb[gi]);
            end
        end
        assign w_j[gi] = w_code[1];
        assign w_k[gi] = w_code[0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode      <= 1'b0;
            r_first     <= 1'b0;
            r_data      <= '0;
            r_expected  <= '0;
            r_fail_bits <= '0;
            r_retry     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mode      <= bus.req_mode;
                        r_data      <= bus.req_data;
                        r_first     <= 1'b1;
                        r_retry     <= '0;
                        r_fail_bits <= '0;
                    end
                end
                DRIVE: begin
                    if (r_first) begin
                        r_expected <= r_mode ? (bus.q_fb ^ r_data) : r_data;
                        r_first    <= 1'b0;
                    end
                end
                CHECK: begin
                    r_fail_bits <= bus.q_fb ^ r_expected;
                    if (w_match)
                        r_done <= 1'b1;
                    else if (r_retry < MAX_R)
                        r_retry <= r_retry + 3'd1;
                    else
                        r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.j_out     = w_j;
    assign bus.k_out     = w_k;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.fail_bits = r_fail_bits;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Scoreboard bench: behavioural JK cells on j_out/k_out, predictions queued at drive time.
module tb_jk_bank_driver;

    localparam int W  = 4;
    localparam int MR = 2;

    typedef struct {
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic [W-1:0] fail;
        logic [W-1:0] cells;
        logic         is_err;
        int           lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jk_bank_driver_if #(.WIDTH(W)) bus();

    jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    logic [W-1:0] cells   = '0;
    logic [W-1:0] stuck   = '0;
    logic [W-1:0] m_cells = '0;

    assign bus.q_fb = cells & ~stuck;

    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            case ({bus.j_out[i], bus.k_out[i]})
                2'b10:   cells[i] <= 1'b1;
                2'b01:   cells[i] <= 1'b0;
                2'b11:   cells[i] <= ~cells[i];
                default: cells[i] <= cells[i];
            endcase
        end
    end

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    int   cyc       = 0;
    int   acc_cyc   = 0;
    int   pulse_cyc = -1;
    bit   exp_drive = 1'b0;
    exp_t hd;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_drive = 1'b0;
        end else begin
            if (!bus.busy)
                chk("jk_idle", {bus.j_out, bus.k_out}, '0);
            if (exp_drive) begin
                exp_drive = 1'b0;
                if (sb.size() == 0) begin
                    chk("drive_no_exp", 1, 0);
                end else begin
                    chk("j_drive", bus.j_out, sb[0].j);
                    chk("k_drive", bus.k_out, sb[0].k);
                end
            end
            if (bus.done || bus.err) begin
                pulse_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("spurious_pulse", {bus.done, bus.err}, 0);
                end else begin
                    hd = sb.pop_front();
                    chk("done", bus.done, !hd.is_err);
                    chk("err", bus.err, hd.is_err);
                    chk("fail_bits", bus.fail_bits, hd.fail);
                    chk("latency", cyc - acc_cyc, hd.lat);
                    chk("cells", cells, hd.cells);
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                exp_drive = 1'b1;
                acc_cyc   = cyc;
            end
        end
    end

    // Predict from the model's cell image, then present the request until accepted.
    task automatic send(input logic mode, input logic [W-1:0] data, input bit hold);
        exp_t         e;
        logic [W-1:0] q;
        logic [W-1:0] tgt;
        bit           ok;
        q = m_cells & ~stuck;
        if (mode) begin
            tgt = m_cells ^ data;
            e.j = data;
            e.k = data;
        end else begin
            tgt = data;
            e.j = data & ~q;
            e.k = ~data & q;
        end
        e.fail   = tgt & stuck;
        e.is_err = (e.fail != '0);
        e.lat    = e.is_err ? 2 * (MR + 1) + 1 : 3;
        e.cells  = tgt;
        sb.push_back(e);
        m_cells = tgt;
        bus.req_valid = 1'b1;
        bus.req_mode  = mode;
        bus.req_data  = data;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            ok = bus.req_ready;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && !bus.busy;
        end
        if (!ok) chk("idle_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_mode  = 1'b0;
        bus.req_data  = '0;
        #12;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_jk", {bus.j_out, bus.k_out}, 0);
        chk("rst_pulse", {bus.done, bus.err}, 0);
        chk("rst_fail_bits", bus.fail_bits, 0);
        #8 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(1'b0, 4'b1010, 1'b0); wait_idle();
        send(1'b1, 4'b0110, 1'b0); wait_idle();

        stuck = 4'b0001;
        send(1'b0, 4'b0001, 1'b0); wait_idle();
        stuck = 4'b0000;

        send(1'b0, 4'b0101, 1'b0); wait_idle();
        send(1'b0, 4'b0101, 1'b0); wait_idle();
        send(1'b1, 4'b0000, 1'b0); wait_idle();

        send(1'b0, 4'b1111, 1'b1);
        send(1'b0, 4'b0011, 1'b0);
        chk("b2b_accept_cycle", acc_cyc, pulse_cyc);
        wait_idle();

        send(1'b0, 4'b1000, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_jk", {bus.j_out, bus.k_out}, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.req_ready, 1);
        chk("mid_rst_pulse", {bus.done, bus.err}, 0);
        chk("mid_rst_fail_bits", bus.fail_bits, 0);
        chk("mid_rst_cells_kept", cells, m_cells);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        send(1'b1, 4'b0011, 1'b0); wait_idle();

        repeat (8) begin
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
